// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the control unit and the multiply/divide unit.
// The control unit is the master; the multiply/divide unit is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_start;
  logic             op_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_start, op_sel, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  op_start, op_sel, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: sign-magnitude operands, one bit per
// cycle (shift-add multiply, restoring divide), results land in HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Datapath for a single iteration step
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mult_step;
  logic [2*WIDTH-1:0] mult_signed;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_step;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH-1:0]   rem_signed;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    add_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    mult_step   = prod_q[0] ? {add_sum, prod_q[WIDTH-1:1]}
                            : {1'b0, prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1:1]};
    mult_signed = (sign_a_q ^ sign_b_q) ? -mult_step : mult_step;

    shifted     = {rem_q, quot_q[WIDTH-1]};
    fits        = (shifted >= {1'b0, mag_b_q});
    // When the divisor fits, the difference is below the divisor, so WIDTH bits suffice
    rem_step    = fits ? (shifted[WIDTH-1:0] - mag_b_q) : shifted[WIDTH-1:0];
    quot_step   = {quot_q[WIDTH-2:0], fits};
    quot_signed = (sign_a_q ^ sign_b_q) ? -quot_step : quot_step;
    rem_signed  = sign_a_q ? -rem_step : rem_step;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.op_start) begin
          sign_a_d   = bus.a[WIDTH-1];
          sign_b_d   = bus.b[WIDTH-1];
          mag_a_d    = magnitude(bus.a);
          mag_b_d    = magnitude(bus.b);
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = CW'(WIDTH);
          if (bus.op_sel) begin
            state_d = S_DIV;
            rem_d   = '0;
            quot_d  = magnitude(bus.a);
          end else begin
            state_d = S_MULT;
            prod_d  = {{WIDTH{1'b0}}, magnitude(bus.b)};
          end
        end
      end

      S_MULT: begin
        prod_d = mult_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = mult_signed[2*WIDTH-1:WIDTH];
          lo_d    = mult_signed[WIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_DIV: begin
        // A zero divisor finishes immediately and leaves HI/LO untouched
        if (mag_b_q == '0) begin
          div_zero_d = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_d    = rem_signed;
            lo_d    = quot_signed;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations, compared against plain signed arithmetic.
module tb_mult_div_unit;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-precision signed arithmetic; SV division truncates toward zero
  function automatic logic [63:0] model(input bit op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (!op) begin
      p = sa * sb;
      return 64'(p);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen
  task automatic do_op(input bit op, input logic [31:0] av, input logic [31:0] bv, input bit repulse);
    logic [63:0] m;
    bit dz;
    int cyc, busy_cnt;
    dz = op && (bv == 32'd0);
    bus.op_start = 1'b1;
    bus.op_sel   = op;
    bus.a        = av;
    bus.b        = bv;
    @(negedge clock);
    bus.op_start = 1'b0;
    bus.op_sel   = ~op;
    bus.a        = $urandom;
    bus.b        = $urandom;
    cyc = 1;
    busy_cnt = 0;
    check("div_zero_cleared", 64'(bus.div_zero), 64'd0);
    while (!bus.done && cyc < 100) begin
      if (bus.busy) busy_cnt++;
      if (cyc == 16) begin
        check("hi_hold", 64'(bus.hi), 64'(exp_hi));
        check("lo_hold", 64'(bus.lo), 64'(exp_lo));
      end
      if (repulse && cyc == 10) begin
        bus.op_start = 1'b1;
        bus.op_sel   = ~op;
        bus.a        = $urandom;
        bus.b        = $urandom;
      end else begin
        bus.op_start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bus.op_start = 1'b0;
    check("latency", 64'(cyc), dz ? 64'd2 : 64'd33);
    check("busy_cycles", 64'(busy_cnt), dz ? 64'd1 : 64'd32);
    check("busy_at_done", 64'(bus.busy), 64'd0);
    if (!dz) begin
      m = model(op, av, bv);
      exp_hi = m[63:32];
      exp_lo = m[31:0];
    end
    check("hi", 64'(bus.hi), 64'(exp_hi));
    check("lo", 64'(bus.lo), 64'(exp_lo));
    check("div_zero", 64'(bus.div_zero), 64'(dz));
    $display("%s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0d lat=%0d",
             op ? "DIV " : "MULT", av, bv, bus.hi, bus.lo, bus.div_zero, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    n_cmp = 0;
    n_err = 0;
    exp_hi = '0;
    exp_lo = '0;
    reset = 1'b1;
    bus.op_start = 1'b0;
    bus.op_sel   = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases, issued back to back (each start lands in the done cycle)
    do_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 32'h0000_0D12, 32'h0000_0040, 1'b0);
    do_op(1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0);
    do_op(1'b0, 32'h0000_0003, 32'h0000_0005, 1'b0);
    do_op(1'b0, 32'h0000_1234, 32'hFFFF_FFAB, 1'b1);

    // Reset in the middle of a multiply
    @(negedge clock);
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    bus.a        = 32'h0000_0099;
    bus.b        = 32'h0000_0077;
    @(negedge clock);
    bus.op_start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    dn = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done || bus.busy) dn++;
    end
    check("no_activity_after_reset", 64'(dn), 64'd0);
    do_op(1'b0, 32'hFFFF_FFF0, 32'h0000_0011, 1'b0);

    // Randomized operations with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_op(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clock);
    check("done_falls", 64'(bus.done), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
